filter_mode_ctrl: RTL and testbench

//  Configures the grayscale filter stage from one pushbutton, in the pix_clk domain.
//  - Debounces the raw key and treats each press as "advance to next mode".
//  - Commits the new mode only at a frame boundary (vsync falling edge), so no frame tears.
//  - Drives registered one-hot enables into the filter stage, between producer and VGA RGB mux.

---
 rtl/filter_mode_ctrl.sv | 124 ++++++++++++
 tb/tb_filter_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_ctrl.sv
// rtl/filter_mode_ctrl.sv - pushbutton-driven filter mode selector, committed on vsync falling edge
module filter_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NUM_MODES       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       vsync,
    output logic [1:0] mode,
    output logic       brighten_en,
    output logic       invert_en,
    output logic       thresh_en,
    output logic       pending,
    output logic       mode_changed
);
    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       LAST_MODE = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    logic             btn_m;
    logic             btn_s;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             vs_q;
    logic [1:0]       next_mode;
    logic             rearm;
    logic             press;
    logic             boundary;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_m <= 1'b1;
            btn_s <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            btn_m <= btn_n;
            btn_s <= btn_m;
            vs_q  <= vsync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (btn_s == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= btn_s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the cycle whose closing edge accepts a new low level.
    assign press    = (btn_s != stable) && (cnt == CNT_LAST) && !btn_s;
    assign boundary = vs_q & ~vsync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_mode <= 2'd0;
        end else if (press) begin
            next_mode <= (next_mode == LAST_MODE) ? 2'd0 : next_mode + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mode         <= 2'd0;
            brighten_en  <= 1'b0;
            invert_en    <= 1'b0;
            thresh_en    <= 1'b0;
            pending      <= 1'b0;
            mode_changed <= 1'b0;
            rearm        <= 1'b0;
        end else begin
            mode_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        state   <= ARMED;
                        pending <= 1'b1;
                    end
                end
                ARMED: begin
                    if (boundary) begin
                        // next_mode is sampled before any coincident press advances it.
                        state        <= COMMIT;
                        pending      <= 1'b0;
                        mode         <= next_mode;
                        brighten_en  <= (next_mode == 2'd1);
                        invert_en    <= (next_mode == 2'd2);
                        thresh_en    <= (next_mode == 2'd3);
                        mode_changed <= 1'b1;
                        rearm        <= press;
                    end
                end
                COMMIT: begin
                    rearm <= 1'b0;
                    if (rearm || press) begin
                        state   <= ARMED;
                        pending <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_filter_mode_ctrl.sv
// tb/tb_filter_mode_ctrl.sv - self-checking bench for filter_mode_ctrl
`timescale 1ns/1ps
module tb_filter_mode_ctrl;
    localparam int D     = 4;
    localparam int NM    = 4;
    localparam int FRAME = 800;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_n   = 1'b1;
    logic       vsync   = 1'b1;
    logic [1:0] mode;
    logic       brighten_en;
    logic       invert_en;
    logic       thresh_en;
    logic       pending;
    logic       mode_changed;

    int compared   = 0;
    int mismatched = 0;
    int vcnt       = 0;
    int pulses     = 0;
    bit cmp_on     = 1'b0;

    filter_mode_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_MODES(NM)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_n        (btn_n),
        .vsync        (vsync),
        .mode         (mode),
        .brighten_en  (brighten_en),
        .invert_en    (invert_en),
        .thresh_en    (thresh_en),
        .pending      (pending),
        .mode_changed (mode_changed)
    );

    always #5 clk = ~clk;

    // Frame timing: vsync low for the first 10 cycles of every 800.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            vcnt  = (vcnt + 1) % FRAME;
            vsync = (vcnt >= 10);
        end
    end

    // Reference model: a level is accepted after D consecutive differing synchronised samples.
    bit m_s1, m_s2, m_stab, m_vprev, m_armed, m_commit, m_carry, m_chg, m_press, m_bnd;
    int m_run, m_next, m_mode;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = 1; m_s2 = 1; m_stab = 1; m_run = 0; m_vprev = 1;
            m_next = 0; m_mode = 0; m_armed = 0; m_commit = 0; m_carry = 0; m_chg = 0;
        end else begin
            m_press = 0;
            if (m_s2 != m_stab) begin
                m_run++;
                if (m_run == D) begin
                    m_stab  = m_s2;
                    m_run   = 0;
                    m_press = !m_stab;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_n;
            m_bnd   = m_vprev && !vsync;
            m_vprev = vsync;
            m_chg   = 0;
            if (m_commit) begin
                m_commit = 0;
                m_armed  = m_carry || m_press;
                m_carry  = 0;
            end else if (m_armed && m_bnd) begin
                m_mode   = m_next;
                m_chg    = 1;
                m_commit = 1;
                m_armed  = 0;
                m_carry  = m_press;
            end else if (m_press) begin
                m_armed = 1;
            end
            if (m_press) m_next = (m_next + 1) % NM;
        end
    end

    task automatic step();
        logic [5:0] got;
        logic [5:0] exp;
        @(negedge clk);
        if (cmp_on) begin
            got = {mode, brighten_en, invert_en, thresh_en, pending, mode_changed};
            exp = {2'(m_mode), (m_mode == 1), (m_mode == 2), (m_mode == 3), m_armed, m_chg};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL cycle_model t=%0t: dut mode,b,i,t,pend,chg=%b model=%b", $time, got, exp);
            end
            if (mode_changed === 1'b1) pulses++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_vcnt(int v);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (vcnt != v && n < 2 * FRAME);
        if (vcnt != v) begin
            compared++;
            mismatched++;
            $display("FAIL wait_vcnt: timed out at vcnt %0d, required %0d", vcnt, v);
        end
    endtask

    task automatic press_clean();
        btn_n = 1'b0;
        repeat (8) step();
        btn_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        cmp_on = 1'b1;
        step();
        chk("reset_outputs", 8'({mode, brighten_en, invert_en, thresh_en, pending, mode_changed}), 8'd0);

        // 1: idle frames leave outputs untouched
        reset_n = 1'b1;
        pulses  = 0;
        repeat (3 * FRAME) step();
        chk("idle_mode", 8'(mode), 8'd0);
        chk("idle_pending", 8'(pending), 8'd0);
        chk("idle_pulses", 8'(pulses), 8'd0);

        // 2: bouncing key settles to one press
        wait_vcnt(100);
        for (int i = 0; i < 10; i++) begin
            btn_n = (i % 2 == 1);
            repeat (2) step();
        end
        btn_n = 1'b0;
        repeat (5) step();
        chk("bounce_pending_early", 8'(pending), 8'd0);
        step();
        chk("bounce_pending_rise", 8'(pending), 8'd1);
        repeat (10) step();
        btn_n  = 1'b1;
        pulses = 0;
        wait_vcnt(0);
        chk("precommit_mode", 8'(mode), 8'd0);
        step();
        chk("commit_mode", 8'(mode), 8'd1);
        chk("commit_brighten", 8'(brighten_en), 8'd1);
        chk("commit_pulse", 8'(mode_changed), 8'd1);
        step();
        chk("pulse_width", 8'(mode_changed), 8'd0);
        wait_vcnt(20);
        chk("bounce_pulses", 8'(pulses), 8'd1);
        chk("bounce_pending_clr", 8'(pending), 8'd0);

        // 3: three presses in one frame, then a wrapping fourth
        do_reset();
        wait_vcnt(100);
        pulses = 0;
        repeat (3) press_clean();
        chk("multi_pending", 8'(pending), 8'd1);
        wait_vcnt(20);
        chk("multi_mode", 8'(mode), 8'd3);
        chk("multi_thresh", 8'(thresh_en), 8'd1);
        chk("multi_pulses", 8'(pulses), 8'd1);
        wait_vcnt(100);
        pulses = 0;
        press_clean();
        wait_vcnt(20);
        chk("wrap_mode", 8'(mode), 8'd0);
        chk("wrap_enables", 8'({brighten_en, invert_en, thresh_en}), 8'd0);
        chk("wrap_pulses", 8'(pulses), 8'd1);

        // 4: press lands on the boundary cycle
        do_reset();
        wait_vcnt(100);
        press_clean();
        chk("collide_armed", 8'(pending), 8'd1);
        wait_vcnt(FRAME - 5);
        btn_n  = 1'b0;
        pulses = 0;
        wait_vcnt(5);
        btn_n = 1'b1;
        chk("collide_mode", 8'(mode), 8'd1);
        chk("collide_rearm", 8'(pending), 8'd1);
        wait_vcnt(20);
        chk("collide_still_pending", 8'(pending), 8'd1);
        wait_vcnt(20);
        chk("collide_next_mode", 8'(mode), 8'd2);
        chk("collide_invert", 8'(invert_en), 8'd1);
        chk("collide_pending_clr", 8'(pending), 8'd0);
        chk("collide_pulses", 8'(pulses), 8'd2);

        // 5: glitch shorter than the debounce window
        wait_vcnt(100);
        pulses = 0;
        btn_n  = 1'b0;
        repeat (3) step();
        btn_n = 1'b1;
        repeat (10) step();
        chk("glitch_pending", 8'(pending), 8'd0);
        wait_vcnt(20);
        chk("glitch_mode", 8'(mode), 8'd2);
        chk("glitch_pulses", 8'(pulses), 8'd0);

        // 6: reset discards a queued press
        wait_vcnt(100);
        press_clean();
        chk("midreset_armed", 8'(pending), 8'd1);
        reset_n = 1'b0;
        repeat (3) step();
        chk("midreset_mode", 8'(mode), 8'd0);
        chk("midreset_pending", 8'(pending), 8'd0);
        reset_n = 1'b1;
        pulses  = 0;
        wait_vcnt(20);
        chk("postreset_mode", 8'(mode), 8'd0);
        chk("postreset_pulses", 8'(pulses), 8'd0);
        chk("postreset_pending", 8'(pending), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
